systolic_feed_ctrl: RTL and testbench

- Sequencer for the 4x4 systolic MAC array (lanes a11..a14, weight registers w11..w44, partial-sum outputs sum4..sum16).
- Buffers one feature matrix and one weight matrix through a write port.
- On start, drives the skewed wavefront feed, zero-flushes, waits for pipeline drain, then captures the array sums.
- Presents the captured sums to the downstream quantiser/limiter with a valid/ready handshake.

---
 rtl/systolic_feed_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
// Sequencer for an N x N systolic MAC array. Buffers one feature matrix and
// one weight matrix through a write port, plays the skewed wavefront into the
// array, flushes with zeros, waits for the pipeline to drain, captures the
// array sums and offers them downstream through a valid/ready handshake.
// Build macro SYSTOLIC_FEED_RELU_EN: when defined, captured lanes are treated
// as signed and negative values are stored as zero.
module systolic_feed_ctrl #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int ACC_W     = 24,
    parameter int DRAIN_CYC = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ld_en,
    input  logic                   ld_sel,
    input  logic [$clog2(N)-1:0]   ld_row,
    input  logic [$clog2(N)-1:0]   ld_col,
    input  logic [DW-1:0]          ld_data,
    input  logic                   start,
    output logic                   busy,
    output logic [N*DW-1:0]        a_out,
    output logic [N*N*DW-1:0]      w_out,
    output logic [N*N-1:0]         w_load,
    output logic [ACC_W-1:0]       carry_in,
    input  logic [N*ACC_W-1:0]     sum_in,
    output logic [N*ACC_W-1:0]     res_data,
    output logic                   res_valid,
    input  logic                   res_ready
);

    localparam int IDX_W = $clog2(N);
    // Wide enough for both the feed step (0..2N-2) and the drain count (0..14);
    // also guarantees 2^CNT_W >= 2N, which the lane-offset wrap test relies on.
    localparam int CNT_W = ($clog2(2 * N) > 4) ? $clog2(2 * N) : 4;
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2 * N - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FEED    = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    state_t                       state_r, state_nxt_s;
    logic [CNT_W-1:0]             cnt_r, cnt_nxt_s;
    logic                         feeding_s;
    logic                         load_ok_s;
    logic [N-1:0][N-1:0][DW-1:0]  feat_s;
    logic [N*DW-1:0]              a_nxt_s;
    logic [N*N*DW-1:0]            w_nxt_s;
    logic [N*N-1:0]               wl_nxt_s;
    logic [N*ACC_W-1:0]           cap_s;

    logic [N*DW-1:0]              a_out_r;
    logic [N*N*DW-1:0]            w_out_r;
    logic [N*N-1:0]               w_load_r;
    logic [N*ACC_W-1:0]           res_data_r;
    logic                         res_valid_r;
    logic                         busy_r;

    // Per-lane capture transform applied to one array sum
    function automatic logic [ACC_W-1:0] capture_lane(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] res;
`ifdef SYSTOLIC_FEED_RELU_EN
        if (v[ACC_W-1]) begin
            res = {ACC_W{1'b0}};
        end else begin
            res = v;
        end
`else
        res = v;
`endif
        return res;
    endfunction

    assign feeding_s = (state_r == ST_FEED);
    assign load_ok_s = ld_en && (state_r == ST_IDLE);

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [DW-1:0] feat_e_r;
            logic [DW-1:0] wgt_e_r;
            logic          wr_s;
            logic          hit_s;

            assign wr_s  = load_ok_s && (ld_row == IDX_W'(r)) && (ld_col == IDX_W'(c));
            // Element (r,c) sits on the anti-diagonal fed at step r+c
            assign hit_s = feeding_s && (cnt_r == CNT_W'(r + c));

            // Buffer element storage: cleared on reset, written by the load port while idle
            always_ff @(posedge clock) begin
                if (!reset) begin
                    feat_e_r <= {DW{1'b0}};
                    wgt_e_r  <= {DW{1'b0}};
                end else if (wr_s && ld_sel) begin
                    wgt_e_r  <= ld_data;
                end else if (wr_s) begin
                    feat_e_r <= ld_data;
                end
            end

            assign feat_s[r][c]                 = feat_e_r;
            assign wl_nxt_s[r*N+c]              = hit_s;
            assign w_nxt_s[(r*N+c)*DW +: DW]    = hit_s ? wgt_e_r : w_out_r[(r*N+c)*DW +: DW];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [CNT_W-1:0] off_s;
        logic             lane_ok_s;
        // Column of row i due at this step; before the lane starts the
        // subtraction wraps to a value >= N, so one compare covers both ends.
        assign off_s     = cnt_r - CNT_W'(i);
        assign lane_ok_s = feeding_s && (off_s < CNT_W'(N));
        assign a_nxt_s[i*DW +: DW]       = lane_ok_s ? feat_s[i][off_s[IDX_W-1:0]] : {DW{1'b0}};
        assign cap_s[i*ACC_W +: ACC_W]   = capture_lane(sum_in[i*ACC_W +: ACC_W]);
    end

    // Next-state and step/drain counter sequencing
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (start) begin
                    state_nxt_s = ST_FEED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (cnt_r == FEED_LAST) begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_FEED;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_DRAIN;
                cnt_nxt_s   = CNT_ZERO;
            end
            ST_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_CAPTURE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_CAPTURE: begin
                state_nxt_s = ST_HOLD;
                cnt_nxt_s   = CNT_ZERO;
            end
            ST_HOLD: begin
                cnt_nxt_s = CNT_ZERO;
                if (res_valid_r && res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered outputs, one cycle behind the state/step register
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_out_r     <= {(N*DW){1'b0}};
            w_out_r     <= {(N*N*DW){1'b0}};
            w_load_r    <= {(N*N){1'b0}};
            res_data_r  <= {(N*ACC_W){1'b0}};
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            a_out_r  <= a_nxt_s;
            w_out_r  <= w_nxt_s;
            w_load_r <= wl_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_CAPTURE: begin
                    res_data_r  <= cap_s;
                    res_valid_r <= 1'b1;
                end
                ST_HOLD: begin
                    res_data_r  <= res_data_r;
                    res_valid_r <= !res_ready;
                end
                default: begin
                    res_data_r  <= res_data_r;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign a_out     = a_out_r;
    assign w_out     = w_out_r;
    assign w_load    = w_load_r;
    assign res_data  = res_data_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;
    assign carry_in  = {ACC_W{1'b0}};

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl
// Scoreboard bench for systolic_feed_ctrl. Stimulus pushes per-cycle feed
// expectations and result expectations computed from a matrix-level model;
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_systolic_feed_ctrl;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int ACC_W     = 24;
    localparam int DRAIN_CYC = 3;
    localparam int IDX_W     = 2;
    // Observable cycles per pass: feed steps, flush, drain, capture
    localparam int PASS_OUT  = (2 * N - 1) + 1 + DRAIN_CYC + 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 ld_en = 1'b0;
    logic                 ld_sel = 1'b0;
    logic [IDX_W-1:0]     ld_row = 2'd0;
    logic [IDX_W-1:0]     ld_col = 2'd0;
    logic [DW-1:0]        ld_data = 8'd0;
    logic                 start = 1'b0;
    logic                 busy;
    logic [N*DW-1:0]      a_out;
    logic [N*N*DW-1:0]    w_out;
    logic [N*N-1:0]       w_load;
    logic [ACC_W-1:0]     carry_in;
    logic [N*ACC_W-1:0]   sum_in = '0;
    logic [N*ACC_W-1:0]   res_data;
    logic                 res_valid;
    logic                 res_ready = 1'b0;

    systolic_feed_ctrl #(.N(N), .DW(DW), .ACC_W(ACC_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clock(clock), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .start(start),
        .busy(busy), .a_out(a_out), .w_out(w_out), .w_load(w_load),
        .carry_in(carry_in), .sum_in(sum_in), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: matrices as the controller should hold them
    logic [DW-1:0] mf [N][N];
    logic [DW-1:0] mw [N][N];
    logic [DW-1:0] w_img [N*N];

    typedef struct {
        int                 cyc;
        logic [N*DW-1:0]    a;
        logic [N*N-1:0]     wl;
        logic [N*N*DW-1:0]  w;
    } feed_t;
    typedef struct {
        int                 rise;
        logic [N*ACC_W-1:0] data;
    } res_t;
    feed_t feed_q[$];
    res_t  res_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mf[r][c] = '0;
                mw[r][c] = '0;
                w_img[r*N+c] = '0;
            end
    endtask

    function automatic logic [N*ACC_W-1:0] model_result(input logic [N*ACC_W-1:0] s);
        logic [N*ACC_W-1:0] r;
        logic signed [ACC_W-1:0] v;
        r = s;
        for (int l = 0; l < N; l++) begin
            v = s[l*ACC_W +: ACC_W];
`ifdef SYSTOLIC_FEED_RELU_EN
            if (v < 0) r[l*ACC_W +: ACC_W] = '0;
`endif
        end
        return r;
    endfunction

    // Called in the cycle start is driven: builds everything the pass must show
    task automatic model_start();
        int c0;
        feed_t e;
        res_t rr;
        c0 = cyc;
        for (int k = 0; k < PASS_OUT; k++) begin
            e.cyc = c0 + 2 + k;
            e.a = '0;
            e.wl = '0;
            if (k < 2 * N - 1) begin
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = k - i;
                    if (j >= 0 && j < N) e.a[i*DW +: DW] = mf[i][j];
                end
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        if (r + c == k) begin
                            e.wl[r*N+c] = 1'b1;
                            w_img[r*N+c] = mw[r][c];
                        end
            end
            for (int x = 0; x < N * N; x++) e.w[x*DW +: DW] = w_img[x];
            feed_q.push_back(e);
        end
        rr.rise = c0 + 1 + PASS_OUT;
        rr.data = model_result(sum_in);
        res_q.push_back(rr);
    endtask

    // Monitor: compares feed outputs by cycle and results on valid/handshake
    bit prev_valid = 1'b0;
    bit hs_seen = 1'b0;
    always @(negedge clock) begin
        if (feed_q.size() > 0 && feed_q[0].cyc == cyc) begin
            check("a_out", a_out, feed_q[0].a);
            check("w_load", w_load, feed_q[0].wl);
            check("w_out", w_out, feed_q[0].w);
            void'(feed_q.pop_front());
        end
        if (hs_seen) begin
            check("valid_drop", res_valid, 1'b0);
            check("busy_drop", busy, 1'b0);
            hs_seen = 1'b0;
        end else if (res_valid) begin
            if (res_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid @cyc %0d: res_valid=1, required 0", cyc);
            end else begin
                if (!prev_valid) check("latency", cyc, res_q[0].rise);
                check("res_data", res_data, res_q[0].data);
                if (res_ready) begin
                    void'(res_q.pop_front());
                    hs_seen = 1'b1;
                end
            end
        end
        prev_valid = res_valid;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input bit sel, input int r, input int c, input logic [DW-1:0] d);
        ld_en = 1'b1;
        ld_sel = sel;
        ld_row = r[IDX_W-1:0];
        ld_col = c[IDX_W-1:0];
        ld_data = d;
        if (sel) mw[r][c] = d;
        else mf[r][c] = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic junk_inputs();
        ld_en = 1'($urandom_range(0, 1));
        ld_sel = 1'($urandom_range(0, 1));
        ld_row = IDX_W'($urandom_range(0, N - 1));
        ld_col = IDX_W'($urandom_range(0, N - 1));
        ld_data = DW'($urandom);
        start = 1'($urandom_range(0, 1));
    endtask

    // One pass: start, optional junk while busy, hold_cyc cycles of backpressure
    task automatic run_pass(input int hold_cyc, input bit junk);
        int waited;
        waited = 0;
        start = 1'b1;
        res_ready = (hold_cyc == 0);
        model_start();
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        check("busy_run", busy, 1'b1);
        while (!res_valid && waited < 40) begin
            if (junk) junk_inputs();
            tick();
            waited++;
        end
        ld_en = 1'b0;
        start = 1'b0;
        if (!res_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL pass_timeout: res_valid=%b after %0d cycles, required 1", res_valid, waited);
            feed_q.delete();
            res_q.delete();
        end
        for (int h = 0; h < hold_cyc; h++) begin
            if (junk) junk_inputs();
            tick();
        end
        ld_en = 1'b0;
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
    endtask

    int f_tab [N][N];

    initial begin
        f_tab = '{'{4, 0, 2, 1}, '{4, 3, 2, 0}, '{4, 3, 0, 1}, '{4, 3, 2, 1}};
        model_clear();

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check("rst_a_out", a_out, '0);
        check("rst_w_out", w_out, '0);
        check("rst_w_load", w_load, '0);
        check("rst_res_data", res_data, '0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("carry_in", carry_in, '0);
        reset = 1'b1;
        tick();

        // Skew feed with the documented matrices, immediate acceptance
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                load(1'b0, r, c, DW'(f_tab[r][c]));
                load(1'b1, r, c, DW'(c + 1));
            end
        sum_in = {24'd40, 24'd30, 24'd20, 24'd10};
        run_pass(0, 1'b0);

        // Backpressure with ignored loads/starts, then replay of the same buffers
        run_pass(5, 1'b1);
        run_pass(0, 1'b0);

        // Negative lane capture
        sum_in = {24'd0, 24'd0, 24'd5, 24'hFFFFF6};
        run_pass(0, 1'b0);

        // Load and start in the same idle cycle
        ld_en = 1'b1;
        ld_sel = 1'b0;
        ld_row = 2'd0;
        ld_col = 2'd0;
        ld_data = 8'd9;
        mf[0][0] = 8'd9;
        run_pass(0, 1'b0);

        // Randomized passes
        repeat (6) begin
            repeat ($urandom_range(1, 8))
                load(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom_range(0, N - 1), DW'($urandom));
            for (int l = 0; l < N; l++) sum_in[l*ACC_W +: ACC_W] = ACC_W'($urandom);
            run_pass($urandom_range(0, 3), 1'b1);
        end

        // Reset during FEED step 2, then a pass that must feed all zeros
        begin
            int c0;
            c0 = cyc;
            start = 1'b1;
            model_start();
            tick();
            start = 1'b0;
            tick();
            tick();
            reset = 1'b0;
            while (feed_q.size() > 0 && feed_q[feed_q.size() - 1].cyc > c0 + 3) void'(feed_q.pop_back());
            res_q.delete();
            tick();
            check("midrst_a_out", a_out, '0);
            check("midrst_w_out", w_out, '0);
            check("midrst_w_load", w_load, '0);
            check("midrst_busy", busy, 1'b0);
            check("midrst_valid", res_valid, 1'b0);
            reset = 1'b1;
            model_clear();
            tick();
        end
        for (int l = 0; l < N; l++) sum_in[l*ACC_W +: ACC_W] = ACC_W'($urandom);
        run_pass(1, 1'b0);

        repeat (3) tick();
        check("feed_q_drained", feed_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
